pc_redirect_controller: RTL and testbench

PC_REDIRECT_CONTROLLER -- requirements
Module: pc_redirect_controller

---
 rtl/pc_redirect_controller.sv | 159 +++++++++++++++
 tb/tb_pc_redirect_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_controller.sv
// pc_redirect_controller
//   Steers the fetch PC and the pipeline-register hold/flush controls for a
//   classic five-stage pipeline. It arbitrates between three sources:
//   branch/jump redirects from EX, load-use bubbles from ID, and data-memory
//   back-pressure. A redirect that arrives while memory is busy is parked in
//   PEND_ADDR and applied on the first cycle the memory frees up.
//
// Ports
//   CLK, RESET             clock and synchronous active-high reset
//   REDIRECT_REQ/ADDR      one-cycle redirect pulse and its target from EX
//   LOAD_USE               load-use hazard seen in ID
//   MEM_BUSY               data memory stall; the whole pipeline freezes
//   PC_WRITE_EN, PC_SEL    PC register enable and PC mux select (1 = target)
//   PC_NEXT_ADDR           redirect target presented to the PC mux
//   *_FLUSH                turn IF/ID or ID/EX into a NOP
//   *_HOLD                 freeze the named pipeline register
//   REDIRECT_CNT/STALL_CNT saturating performance counters
module pc_redirect_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REDIRECT_REQ,
  input  logic [31:0]      REDIRECT_ADDR,
  input  logic             LOAD_USE,
  input  logic             MEM_BUSY,
  output logic             PC_WRITE_EN,
  output logic             PC_SEL,
  output logic [31:0]      PC_NEXT_ADDR,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             IF_ID_HOLD,
  output logic             ID_EX_HOLD,
  output logic             EX_MEM_HOLD,
  output logic             MEM_WB_HOLD,
  output logic [CNT_W-1:0] REDIRECT_CNT,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_PENDING  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]   redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // Next-state and Mealy output logic. Outputs react to the current inputs
  // in the same cycle so a redirect or stall costs no extra latency.
  // MEM_WAIT behaves exactly like RUN once memory is free; while memory is
  // busy (in either state) redirects and load-use requests are dropped,
  // except that RUN captures a redirect into PEND_ADDR so it is not lost.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    PC_WRITE_EN = 1'b1;
    PC_SEL      = 1'b0;
    IF_ID_FLUSH = 1'b0;
    ID_EX_FLUSH = 1'b0;
    IF_ID_HOLD  = 1'b0;
    ID_EX_HOLD  = 1'b0;
    EX_MEM_HOLD = 1'b0;
    MEM_WB_HOLD = 1'b0;

    if (RESET) begin
      // Keep the PC still and feed NOPs into the front of the pipe; any
      // parked redirect is thrown away.
      PC_WRITE_EN = 1'b0;
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
      state_d     = ST_RUN;
      pend_addr_d = 32'h0;
    end else begin
      case (state_q)
        ST_PENDING: begin
          if (MEM_BUSY) begin
            PC_WRITE_EN = 1'b0;
            IF_ID_HOLD  = 1'b1;
            ID_EX_HOLD  = 1'b1;
            EX_MEM_HOLD = 1'b1;
            MEM_WB_HOLD = 1'b1;
          end else begin
            PC_SEL      = 1'b1;
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
            state_d     = ST_RUN;
          end
        end
        ST_RUN, ST_MEM_WAIT: begin
          if (MEM_BUSY) begin
            PC_WRITE_EN = 1'b0;
            IF_ID_HOLD  = 1'b1;
            ID_EX_HOLD  = 1'b1;
            EX_MEM_HOLD = 1'b1;
            MEM_WB_HOLD = 1'b1;
            if ((state_q == ST_RUN) && REDIRECT_REQ) begin
              pend_addr_d = REDIRECT_ADDR;
              state_d     = ST_PENDING;
            end else begin
              state_d     = ST_MEM_WAIT;
            end
          end else begin
            state_d = ST_RUN;
            if (REDIRECT_REQ) begin
              // Redirect wins over load-use: the hazarding instruction is
              // on the wrong path and is flushed anyway.
              PC_SEL      = 1'b1;
              IF_ID_FLUSH = 1'b1;
              ID_EX_FLUSH = 1'b1;
            end else if (LOAD_USE) begin
              PC_WRITE_EN = 1'b0;
              IF_ID_HOLD  = 1'b1;
              ID_EX_FLUSH = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // The target mux does not depend on PC_SEL so the bus stays stable.
  assign PC_NEXT_ADDR = (state_q == ST_PENDING) ? pend_addr_q : REDIRECT_ADDR;

  // Saturating counters; they stop at all-ones instead of wrapping.
  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (RESET) begin
      redirect_cnt_d = '0;
      stall_cnt_d    = '0;
    end else begin
      if (PC_SEL && (redirect_cnt_q != {CNT_W{1'b1}})) begin
        redirect_cnt_d = redirect_cnt_q + 1'b1;
      end
      if (!PC_WRITE_EN && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  // All clocked state: FSM state, parked redirect target and counters.
  // Reset values come through the _d logic above.
  always_ff @(posedge CLK) begin
    state_q        <= state_d;
    pend_addr_q    <= pend_addr_d;
    redirect_cnt_q <= redirect_cnt_d;
    stall_cnt_q    <= stall_cnt_d;
  end

  assign REDIRECT_CNT = redirect_cnt_q;
  assign STALL_CNT    = stall_cnt_q;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// tb_pc_redirect_controller
//   Directed bench for pc_redirect_controller. Inputs change on the falling
//   edge and outputs are sampled 1 time unit later, so combinational outputs
//   reflect the current cycle and counters reflect all previous rising edges.
module tb_pc_redirect_controller;

  localparam int CNT_W = 16;

  // Control vector layout:
  // {PC_WRITE_EN, PC_SEL, IF_ID_FLUSH, ID_EX_FLUSH,
  //  IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD}
  localparam logic [7:0] CTRL_NORMAL   = 8'b1000_0000;
  localparam logic [7:0] CTRL_REDIRECT = 8'b1111_0000;
  localparam logic [7:0] CTRL_BUBBLE   = 8'b0001_1000;
  localparam logic [7:0] CTRL_STALL    = 8'b0000_1111;
  localparam logic [7:0] CTRL_RESET    = 8'b0011_0000;

  logic             clock;
  logic             reset;
  logic             redirectReq;
  logic [31:0]      redirectAddr;
  logic             loadUse;
  logic             memBusy;
  logic             pcWriteEn;
  logic             pcSel;
  logic [31:0]      pcNextAddr;
  logic             ifIdFlush;
  logic             idExFlush;
  logic             ifIdHold;
  logic             idExHold;
  logic             exMemHold;
  logic             memWbHold;
  logic [CNT_W-1:0] redirectCnt;
  logic [CNT_W-1:0] stallCnt;
  logic [7:0]       observedCtrl;

  int totalChecks = 0;
  int badChecks   = 0;

  pc_redirect_controller #(.CNT_W(CNT_W)) dut (
    .CLK           (clock),
    .RESET         (reset),
    .REDIRECT_REQ  (redirectReq),
    .REDIRECT_ADDR (redirectAddr),
    .LOAD_USE      (loadUse),
    .MEM_BUSY      (memBusy),
    .PC_WRITE_EN   (pcWriteEn),
    .PC_SEL        (pcSel),
    .PC_NEXT_ADDR  (pcNextAddr),
    .IF_ID_FLUSH   (ifIdFlush),
    .ID_EX_FLUSH   (idExFlush),
    .IF_ID_HOLD    (ifIdHold),
    .ID_EX_HOLD    (idExHold),
    .EX_MEM_HOLD   (exMemHold),
    .MEM_WB_HOLD   (memWbHold),
    .REDIRECT_CNT  (redirectCnt),
    .STALL_CNT     (stallCnt)
  );

  assign observedCtrl = {pcWriteEn, pcSel, ifIdFlush, idExFlush,
                         ifIdHold, idExHold, exMemHold, memWbHold};

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs on the falling edge and let them settle.
  task automatic applyStimulus(input logic rst, input logic req,
                               input logic [31:0] addr, input logic lu,
                               input logic busy);
    @(negedge clock);
    reset        = rst;
    redirectReq  = req;
    redirectAddr = addr;
    loadUse      = lu;
    memBusy      = busy;
    #1;
  endtask

  // One counted comparison.
  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    totalChecks++;
    assert (observed === expected)
    else begin
      badChecks++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare control vector, target bus and both counters.
  task automatic checkOutput(input string tag, input logic [7:0] expCtrl,
                             input logic [31:0] expAddr,
                             input logic [CNT_W-1:0] expRedirects,
                             input logic [CNT_W-1:0] expStalls);
    checkValue({tag, ".ctrl"}, {24'h0, observedCtrl}, {24'h0, expCtrl});
    checkValue({tag, ".addr"}, pcNextAddr, expAddr);
    checkValue({tag, ".rcnt"}, {16'h0, redirectCnt}, {16'h0, expRedirects});
    checkValue({tag, ".scnt"}, {16'h0, stallCnt}, {16'h0, expStalls});
  endtask

  initial begin
    reset        = 1'b1;
    redirectReq  = 1'b0;
    redirectAddr = 32'h0;
    loadUse      = 1'b0;
    memBusy      = 1'b0;

    // Reset with every request active: all inputs must be ignored.
    applyStimulus(1'b1, 1'b1, 32'h0000_0ABC, 1'b1, 1'b1);
    checkValue("reset0.ctrl", {24'h0, observedCtrl}, {24'h0, CTRL_RESET});
    applyStimulus(1'b1, 1'b1, 32'h0000_0ABC, 1'b1, 1'b1);
    checkOutput("reset1", CTRL_RESET, 32'h0000_0ABC, 16'd0, 16'd0);

    // Idle: sequential fetch, target bus follows REDIRECT_ADDR.
    applyStimulus(1'b0, 1'b0, 32'h0000_1234, 1'b0, 1'b0);
    checkOutput("idle", CTRL_NORMAL, 32'h0000_1234, 16'd0, 16'd0);

    // Plain redirect to 0x100.
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    checkOutput("redir100", CTRL_REDIRECT, 32'h0000_0100, 16'd0, 16'd0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("afterRedir", CTRL_NORMAL, 32'h0000_0000, 16'd1, 16'd0);

    // One-cycle load-use bubble.
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    checkOutput("loadUse", CTRL_BUBBLE, 32'h0000_0000, 16'd1, 16'd0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("afterLu", CTRL_NORMAL, 32'h0000_0000, 16'd1, 16'd1);

    // Redirect to 0x200 while memory is busy for 3 cycles.
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    checkOutput("pend1", CTRL_STALL, 32'h0000_0200, 16'd1, 16'd1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0999, 1'b1, 1'b1);
    checkOutput("pend2", CTRL_STALL, 32'h0000_0200, 16'd1, 16'd2);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    checkOutput("pend3", CTRL_STALL, 32'h0000_0200, 16'd1, 16'd3);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("pendApply", CTRL_REDIRECT, 32'h0000_0200, 16'd1, 16'd4);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("afterPend", CTRL_NORMAL, 32'h0000_0000, 16'd2, 16'd4);

    // Redirect and load-use together: redirect wins, no stall counted.
    applyStimulus(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b0);
    checkOutput("redirLu", CTRL_REDIRECT, 32'h0000_0400, 16'd2, 16'd4);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("afterRedirLu", CTRL_NORMAL, 32'h0000_0000, 16'd3, 16'd4);

    // MEM_WAIT: requests ignored while busy, RUN rules once free.
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    checkOutput("wait1", CTRL_STALL, 32'h0000_0000, 16'd3, 16'd4);
    applyStimulus(1'b0, 1'b1, 32'h0000_0777, 1'b1, 1'b1);
    checkOutput("wait2", CTRL_STALL, 32'h0000_0777, 16'd3, 16'd5);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    checkOutput("waitExitLu", CTRL_BUBBLE, 32'h0000_0000, 16'd3, 16'd6);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("waitDone", CTRL_NORMAL, 32'h0000_0000, 16'd3, 16'd7);

    // Pending redirect to 0x300 discarded by reset.
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1);
    checkOutput("pendRst1", CTRL_STALL, 32'h0000_0300, 16'd3, 16'd7);
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    checkOutput("pendRst2", CTRL_RESET, 32'h0000_0300, 16'd3, 16'd8);
    applyStimulus(1'b0, 1'b0, 32'h0000_0055, 1'b0, 1'b0);
    checkOutput("pendRst3", CTRL_NORMAL, 32'h0000_0055, 16'd0, 16'd0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("pendRst4", CTRL_NORMAL, 32'h0000_0000, 16'd0, 16'd0);

    // Stall counter saturation: 65534 busy cycles bring it to 0xFFFE.
    for (int i = 0; i < 65534; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
      checkOutput("satBusy", CTRL_STALL, 32'h0000_0000, 16'd0,
                  (i == 0) ? 16'hFFFE : 16'hFFFF);
    end
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("satHold", CTRL_NORMAL, 32'h0000_0000, 16'd0, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
